// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary to packed-BCD converter, optional sign digit.
// Latency: Size shift cycles plus one DONE cycle; Done pulses one cycle.
// No backpressure: Start is ignored while Busy, results are not held back.
package General;
    localparam logic [3:0] Minus = 4'hA;
    localparam logic [3:0] Empty = 4'hF;

    // Number of decimal digits needed for values 0 .. n-1.
    function automatic int clog10(input longint n);
        longint v;
        int     r;
        v = 1;
        r = 0;
        for (int i = 0; i < 20; i++) begin
            if (v < n) begin
                v = v * 10;
                r = r + 1;
            end
        end
        return r;
    endfunction
endpackage

module bin_to_bcd_serial #(
    parameter int    Size   = 4,
    parameter string Signed = "Yes",
    localparam bit   IsSigned = (Signed == "Yes"),
    localparam int   ISize    = IsSigned ? General::clog10(longint'(1) << (Size - 1)) + 1
                                         : General::clog10(longint'(1) << Size),
    localparam int   BCDSize  = 4 * ISize
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [Size-1:0]    Data,
    output logic               Busy,
    output logic               Done,
    output logic [BCDSize-1:0] BCD
);

    localparam int AccW   = IsSigned ? 4 * (ISize - 1) : 4 * ISize;
    localparam int Digits = AccW / 4;
    localparam int CntW   = $clog2(Size + 1);
    localparam logic [BCDSize-1:0] BcdRst =
        IsSigned ? (BCDSize'(General::Empty) << (BCDSize - 4)) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [Size-1:0]     sr_q, sr_d, mag;
    logic [AccW-1:0]     acc_q, acc_d, acc_adj, acc_sh;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          sign_q, sign_d;
    logic [BCDSize-1:0]  bcd_q, bcd_d, bcd_next;
    logic                accept;

    assign accept = Start && (state_q != SHIFT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CntW'(1)) state_d = DONE;
            DONE:    state_d = Start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == SHIFT);
        Done = (state_q == DONE);
    end

    assign BCD = bcd_q;

    // Magnitude fits in Size bits even for the most negative input.
    always_comb begin
        mag = Data;
        if (IsSigned && Data[Size-1]) begin
            mag = ~Data + Size'(1);
        end
    end

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < Digits; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_sh = {acc_adj[AccW-2:0], sr_q[Size-1]};
    end

    generate
        if (IsSigned) begin : g_signed
            assign bcd_next = {sign_q, acc_sh};
        end else begin : g_unsigned
            assign bcd_next = acc_sh;
        end
    endgenerate

    always_comb begin
        sr_d   = sr_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        sign_d = sign_q;
        bcd_d  = bcd_q;
        if (accept) begin
            sr_d   = mag;
            acc_d  = '0;
            cnt_d  = CntW'(Size);
            sign_d = (IsSigned && Data[Size-1]) ? General::Minus : General::Empty;
        end else if (state_q == SHIFT) begin
            sr_d  = sr_q << 1;
            acc_d = acc_sh;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                bcd_d = bcd_next;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sr_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            sign_q <= General::Empty;
            bcd_q  <= BcdRst;
        end else begin
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sign_q <= sign_d;
            bcd_q  <= bcd_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: four instances (8/6 bit, signed/unsigned) share Start.
module tb_bin_to_bcd_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] data8;
    logic [5:0] data6;
    logic       busy8u, done8u, busy8s, done8s, busy6u, done6u, busy6s, done6s;
    logic [11:0] bcd8u;
    logic [15:0] bcd8s;
    logic [7:0]  bcd6u;
    logic [11:0] bcd6s;

    bin_to_bcd_serial #(.Size(8), .Signed("No")) u8u (
        .Clock(clk), .Reset(rst), .Start(start), .Data(data8),
        .Busy(busy8u), .Done(done8u), .BCD(bcd8u));
    bin_to_bcd_serial #(.Size(8), .Signed("Yes")) u8s (
        .Clock(clk), .Reset(rst), .Start(start), .Data(data8),
        .Busy(busy8s), .Done(done8s), .BCD(bcd8s));
    bin_to_bcd_serial #(.Size(6), .Signed("No")) u6u (
        .Clock(clk), .Reset(rst), .Start(start), .Data(data6),
        .Busy(busy6u), .Done(done6u), .BCD(bcd6u));
    bin_to_bcd_serial #(.Size(6), .Signed("Yes")) u6s (
        .Clock(clk), .Reset(rst), .Start(start), .Data(data6),
        .Busy(busy6s), .Done(done6s), .BCD(bcd6s));

    int passed = 0;
    int total  = 0;
    logic [15:0] q8u[$], q8s[$], q6u[$], q6s[$];
    int n_push8 = 0, n_push6 = 0;
    int n_done8u = 0, n_done8s = 0, n_done6u = 0, n_done6s = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic spurious(input string name);
        total++;
        $display("FAIL %s: got Done with no conversion pending, expected none", name);
    endtask

    function automatic logic [15:0] dec(input int mag, input int ndig);
        logic [15:0] r;
        int m;
        r = '0;
        m = mag;
        for (int i = 0; i < ndig; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_s(input int v, input int size, input int ndig);
        logic [15:0] r;
        bit neg;
        neg = (v >= (1 << (size - 1)));
        r = dec(neg ? (1 << size) - v : v, ndig);
        r[4*ndig +: 4] = neg ? General::Minus : General::Empty;
        return r;
    endfunction

    task automatic push8(input logic [7:0] d);
        q8u.push_back(dec(int'(d), 3));
        q8s.push_back(exp_s(int'(d), 8, 3));
        n_push8++;
    endtask

    task automatic push6(input logic [5:0] d);
        q6u.push_back(dec(int'(d), 2));
        q6s.push_back(exp_s(int'(d), 6, 2));
        n_push6++;
    endtask

    // Scoreboard: every Done pops the oldest expected value for that instance.
    always @(negedge clk) begin
        logic [15:0] e;
        if (done8u) begin
            n_done8u++;
            if (q8u.size() == 0) spurious("u8u done");
            else begin e = q8u.pop_front(); check("u8u bcd", 64'(bcd8u), 64'(e[11:0])); end
        end
        if (done8s) begin
            n_done8s++;
            if (q8s.size() == 0) spurious("u8s done");
            else begin e = q8s.pop_front(); check("u8s bcd", 64'(bcd8s), 64'(e)); end
        end
        if (done6u) begin
            n_done6u++;
            if (q6u.size() == 0) spurious("u6u done");
            else begin e = q6u.pop_front(); check("u6u bcd", 64'(bcd6u), 64'(e[7:0])); end
        end
        if (done6s) begin
            n_done6s++;
            if (q6s.size() == 0) spurious("u6s done");
            else begin e = q6s.pop_front(); check("u6s bcd", 64'(bcd6s), 64'(e[11:0])); end
        end
    end

    // Entered just after a rising edge with every instance idle; leaves the same way.
    task automatic run_conv(input logic [7:0] d8, input logic [5:0] d6,
                            input logic [15:0] e8u, input logic [15:0] e8s,
                            input logic [15:0] e6u, input logic [15:0] e6s);
        logic [8:0] bt8, dt8, bt6, dt6;
        start = 1'b1;
        data8 = d8;
        data6 = d6;
        q8u.push_back(e8u); q8s.push_back(e8s); n_push8++;
        q6u.push_back(e6u); q6s.push_back(e6s); n_push6++;
        @(posedge clk); #1;
        data8 = ~d8;
        data6 = ~d6;
        bt8 = '0; dt8 = '0; bt6 = '0; dt6 = '0;
        for (int k = 1; k <= 9; k++) begin
            start = (k == 3 || k == 4);
            if (start) begin
                data8 = 8'($urandom);
                data6 = 6'($urandom);
            end
            @(negedge clk);
            bt8[k-1] = busy8u; dt8[k-1] = done8u;
            bt6[k-1] = busy6s; dt6[k-1] = done6s;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("u8u busy trace", 64'(bt8), 64'h0ff);
        check("u8u done trace", 64'(dt8), 64'h100);
        check("u6s busy trace", 64'(bt6), 64'h03f);
        check("u6s done trace", 64'(dt6), 64'h040);
        @(negedge clk);
        check("u8u hold", 64'(bcd8u), 64'(e8u[11:0]));
        check("u6s hold", 64'(bcd6s), 64'(e6s[11:0]));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  d8;
        logic [5:0]  d6;
        logic [15:0] e8u, e8s, e6u, e6s;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd255, 6'd63, 16'h0255, {General::Minus, 12'h001}, 16'h0063, {4'h0, General::Minus, 8'h01}};
        vecs[1] = '{8'h80,  6'd32, 16'h0128, {General::Minus, 12'h128}, 16'h0032, {4'h0, General::Minus, 8'h32}};
        vecs[2] = '{8'h7F,  6'd31, 16'h0127, {General::Empty, 12'h127}, 16'h0031, {4'h0, General::Empty, 8'h31}};
        vecs[3] = '{8'd0,   6'd0,  16'h0000, {General::Empty, 12'h000}, 16'h0000, {4'h0, General::Empty, 8'h00}};
        vecs[4] = '{8'd100, 6'd1,  16'h0100, {General::Empty, 12'h100}, 16'h0001, {4'h0, General::Empty, 8'h01}};
        vecs[5] = '{8'd99,  6'd10, 16'h0099, {General::Empty, 12'h099}, 16'h0010, {4'h0, General::Empty, 8'h10}};

        rst = 1'b1; start = 1'b0; data8 = '0; data6 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy/done", 64'({busy8u, done8u, busy8s, done8s, busy6u, done6u, busy6s, done6s}), 64'h0);
        check("reset u8u bcd", 64'(bcd8u), 64'h000);
        check("reset u8s bcd", 64'(bcd8s), 64'({General::Empty, 12'h000}));
        check("reset u6s bcd", 64'(bcd6s), 64'({General::Empty, 8'h00}));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].d8, vecs[i].d6, vecs[i].e8u, vecs[i].e8s, vecs[i].e6u, vecs[i].e6s);
        end

        for (int v = 0; v < 64; v++) begin
            logic [7:0] r8;
            r8 = 8'($urandom);
            run_conv(r8, 6'(v), dec(int'(r8), 3), exp_s(int'(r8), 8, 3),
                     dec(v, 2), exp_s(v, 6, 2));
        end

        // Start held high, Data changing every cycle.
        start = 1'b1;
        for (int c = 0; c < 63; c++) begin
            data8 = 8'($urandom);
            data6 = 6'($urandom);
            if (c % 9 == 0) push8(data8);
            if (c % 7 == 0) push6(data6);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        run_conv(8'd255, 6'd63, 16'h0255, {General::Minus, 12'h001}, 16'h0063, {4'h0, General::Minus, 8'h01});

        // Abort in the 4th shift cycle, Start also high to test reset priority.
        start = 1'b1; data8 = 8'd200; data6 = 6'd50;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("pre-abort busy", 64'(busy8u), 64'h1);
        @(negedge clk);
        check("abort busy/done", 64'({busy8u, done8u, busy8s, done8s, busy6u, done6u, busy6s, done6s}), 64'h0);
        check("abort u8u bcd", 64'(bcd8u), 64'h000);
        check("abort u8s bcd", 64'(bcd8s), 64'({General::Empty, 12'h000}));
        check("abort u6u bcd", 64'(bcd6u), 64'h00);
        check("abort u6s bcd", 64'(bcd6s), 64'({General::Empty, 8'h00}));
        @(posedge clk); #1;
        @(negedge clk);
        check("reset+start busy", 64'({busy8u, busy6s}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_conv(8'h80, 6'd32, 16'h0128, {General::Minus, 12'h128}, 16'h0032, {4'h0, General::Minus, 8'h32});

        repeat (12) begin @(posedge clk); #1; end
        check("u8u queue drained", 64'(q8u.size()), 64'h0);
        check("u6s queue drained", 64'(q6s.size()), 64'h0);
        check("u8u done count", 64'(n_done8u), 64'(n_push8));
        check("u8s done count", 64'(n_done8s), 64'(n_push8));
        check("u6u done count", 64'(n_done6u), 64'(n_push6));
        check("u6s done count", 64'(n_done6s), 64'(n_push6));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
